// File: rtl/tube_event_recorder_pkg.sv
// Shared types and constants for the drift-tube event recorder.
// Header id and no-hit time are both the all-ones pattern of their field.
package tube_event_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    DRAIN,
    CLEAR
  } state_e;

  localparam logic [31:0] HDR_ID      = '1;
  localparam logic [31:0] NO_HIT_TIME = '1;

endpackage

// File: rtl/tube_event_recorder_if.sv
// Output word stream towards the downstream FIFO.
// A word moves on any cycle with out_valid and out_ready both high.
interface tube_event_recorder_if #(
  parameter int W = 16
) ();

  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/tube_hit_timer.sv
// One drift-tube channel: hit flag plus the window counter value
// at the first hit; later hits in the same event are ignored.
module tube_hit_timer #(
  parameter int TIME_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              tube_i,
  input  logic [TIME_W-1:0] cnt_i,
  output logic              hit_o,
  output logic [TIME_W-1:0] time_o
);

  logic              hit_q;
  logic [TIME_W-1:0] time_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      hit_q  <= 1'b0;
      time_q <= '0;
    end else if (en_i && tube_i && !hit_q) begin
      hit_q  <= 1'b1;
      time_q <= cnt_i;
    end
  end

  assign hit_o  = hit_q;
  assign time_o = time_q;

endmodule

// File: rtl/tube_event_recorder.sv
// Trigger-started hit window over NUM_CH drift tubes, then a drain of
// one header word and per-channel time/id words over a valid/ready port.
module tube_event_recorder
  import tube_event_recorder_pkg::*;
#(
  parameter int NUM_CH  = 32,
  parameter int WIN_CYC = 255,
  parameter int TIME_W  = 8,
  parameter int ID_W    = 8
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              trig_in,
  input  logic [NUM_CH-1:0] tube_in,
  input  logic              zs_en,
  tube_event_recorder_if.master m,
  output logic              busy,
  output logic [15:0]       evt_count,
  output logic [15:0]       missed_trig
);

  localparam int W = TIME_W + ID_W;

  state_e            state_q;
  logic              trig_q;
  logic              zs_q;
  logic [TIME_W-1:0] cnt_q;
  logic [ID_W-1:0]   idx_q;
  logic              vld_q;
  logic [W-1:0]      data_q;
  logic [15:0]       evt_q;
  logic [15:0]       miss_q;

  logic [NUM_CH-1:0] hit;
  logic [TIME_W-1:0] tm [NUM_CH];

  logic              rise;
  logic              win_last;
  logic              nxt_found;
  logic [ID_W-1:0]   nxt_idx;
  logic [W-1:0]      nxt_word;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tube_hit_timer #(.TIME_W(TIME_W)) u_ch (
      .clk_i  (clk100),
      .rst_i  (rst),
      .clr_i  (state_q == CLEAR),
      .en_i   (state_q == WINDOW),
      .tube_i (tube_in[g]),
      .cnt_i  (cnt_q),
      .hit_o  (hit[g]),
      .time_o (tm[g])
    );
  end

  assign rise     = trig_in & ~trig_q;
  assign win_last = cnt_q == TIME_W'(WIN_CYC - 1);

  // Lowest channel at or above idx_q that is due for output.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    nxt_word  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= int'(idx_q) && (!zs_q || hit[i])) begin
        nxt_found = 1'b1;
        nxt_idx   = ID_W'(i);
        nxt_word  = {hit[i] ? tm[i] : NO_HIT_TIME[TIME_W-1:0],
                     ID_W'(i)};
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      zs_q    <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      evt_q   <= '0;
      miss_q  <= '0;
    end else begin
      trig_q <= trig_in;
      if (rise && state_q != IDLE && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= WINDOW;
            cnt_q   <= '0;
            zs_q    <= zs_en;
          end
        end
        WINDOW: begin
          cnt_q <= cnt_q + TIME_W'(1);
          if (win_last) begin
            state_q <= DRAIN;
            vld_q   <= 1'b1;
            data_q  <= {evt_q[TIME_W-1:0], HDR_ID[ID_W-1:0]};
            idx_q   <= '0;
          end
        end
        DRAIN: begin
          if (vld_q && m.out_ready) begin
            if (nxt_found) begin
              data_q <= nxt_word;
              idx_q  <= nxt_idx + ID_W'(1);
            end else begin
              vld_q   <= 1'b0;
              state_q <= CLEAR;
            end
          end
        end
        CLEAR: begin
          evt_q   <= evt_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.out_data  = data_q;
  assign m.out_valid = vld_q;
  assign busy        = state_q != IDLE;
  assign evt_count   = evt_q;
  assign missed_trig = miss_q;

endmodule

// File: tb/tb_tube_event_recorder.sv
// Directed and random events against a first-hit / word-list model
// of the recorder, checked with immediate assertions.
module tb_tube_event_recorder;

  localparam int NCH = 32;
  localparam int WIN = 255;

  logic           clk100 = 1'b0;
  logic           rst = 1'b0;
  logic           trig_in = 1'b0;
  logic [NCH-1:0] tube_in = '0;
  logic           zs_en = 1'b0;
  logic           busy;
  logic [15:0]    evt_count;
  logic [15:0]    missed_trig;

  tube_event_recorder_if #(.W(16)) bus ();

  tube_event_recorder dut (
    .clk100      (clk100),
    .rst         (rst),
    .trig_in     (trig_in),
    .tube_in     (tube_in),
    .zs_en       (zs_en),
    .m           (bus),
    .busy        (busy),
    .evt_count   (evt_count),
    .missed_trig (missed_trig)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;
  int evt_exp = 0;
  int miss_exp = 0;

  logic [NCH-1:0] tubes [WIN];
  logic [15:0]    expq [$];

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NCH-1:0] sparse();
    logic [NCH-1:0] v;
    v = '1;
    for (int j = 0; j < 8; j++) v = v & NCH'($urandom);
    return v;
  endfunction

  // pat: 0 ch3 from 10 + ch7 at 254, 1 ch5 at 20/40, 2 none, 3 random
  task automatic build(input int pat);
    for (int k = 0; k < WIN; k++) begin
      tubes[k] = '0;
      unique case (pat)
        0: begin
          if (k >= 10) tubes[k][3] = 1'b1;
          if (k == 254) tubes[k][7] = 1'b1;
        end
        1: if (k == 20 || k == 40) tubes[k][5] = 1'b1;
        2: ;
        default: tubes[k] = sparse();
      endcase
    end
  endtask

  task automatic model(input bit zs);
    int first [NCH];
    logic [7:0] t;
    expq.delete();
    for (int c = 0; c < NCH; c++) begin
      first[c] = -1;
      for (int k = 0; k < WIN; k++)
        if (first[c] < 0 && tubes[k][c]) first[c] = k;
    end
    t = 8'(evt_exp % 256);
    expq.push_back({t, 8'hFF});
    for (int c = 0; c < NCH; c++) begin
      if (first[c] >= 0) expq.push_back({8'(first[c]), 8'(c)});
      else if (!zs) expq.push_back({8'hFF, 8'(c)});
    end
  endtask

  // rmode: 0 always ready, 1 toggle, 2 random; abort_at >= 0 resets
  task automatic run_event(input bit zs, input int pat, input int rmode,
                           input bit extra, input bit hold,
                           input int abort_at);
    int n;
    int guard;
    bit r;
    bit stalled;
    logic [15:0] prev;
    build(pat);
    model(zs);
    zs_en   = zs;
    trig_in = 1'b1;
    tick();
    zs_en = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      tube_in = tubes[k];
      if (hold) trig_in = 1'b1;
      else trig_in = extra && (k == 50 || k == 100 || k == 150);
      if (k == 0 || k == WIN - 1) begin
        chk("win_busy", 32'(busy), 1);
        chk("win_valid", 32'(bus.out_valid), 0);
      end
      tick();
    end
    tube_in = '0;
    if (!hold) trig_in = 1'b0;
    if (extra) miss_exp += 3;
    n = 0;
    guard = 0;
    stalled = 1'b0;
    prev = '0;
    while (n < expq.size() && guard < 400) begin
      unique case (rmode)
        0: r = 1'b1;
        1: r = guard[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_evt", 32'(evt_count), 0);
        chk("rst_miss", 32'(missed_trig), 0);
        evt_exp = 0;
        miss_exp = 0;
        tick();
        return;
      end
      chk("drain_valid", 32'(bus.out_valid), 1);
      if (stalled) chk("stall_stable", 32'(bus.out_data), 32'(prev));
      if (r && bus.out_valid) begin
        chk($sformatf("word%0d", n), 32'(bus.out_data), 32'(expq[n]));
        n++;
      end
      stalled = bus.out_valid && !r;
      prev = bus.out_data;
      tick();
      guard++;
    end
    bus.out_ready = 1'b1;
    chk("nwords", 32'(n), 32'(expq.size()));
    chk("clr_valid", 32'(bus.out_valid), 0);
    chk("clr_busy", 32'(busy), 1);
    tick();
    evt_exp++;
    chk("idle_busy", 32'(busy), 0);
    chk("evt_count", 32'(evt_count), 32'(evt_exp % 65536));
    chk("missed", 32'(missed_trig), 32'(miss_exp));
    if (hold) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("hold_no_start", 32'(busy), 0);
      end
      trig_in = 1'b0;
    end
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_data", 32'(bus.out_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_evt", 32'(evt_count), 0);
    chk("reset_miss", 32'(missed_trig), 0);
    tick();

    run_event(1'b0, 0, 0, 1'b0, 1'b0, -1);
    chk("ev0_len", 32'(expq.size()), 33);
    chk("ev0_ch3", 32'(expq[4]), 32'h0A03);
    run_event(1'b1, 1, 0, 1'b0, 1'b0, -1);
    chk("zs_len", 32'(expq.size()), 2);
    run_event(1'b1, 2, 0, 1'b0, 1'b0, -1);
    run_event(1'b0, 3, 1, 1'b0, 1'b0, -1);
    run_event(1'b1, 3, 2, 1'b1, 1'b0, -1);
    chk("missed3", 32'(missed_trig), 3);
    run_event(1'b0, 3, 2, 1'b0, 1'b1, -1);
    run_event(1'b0, 3, 0, 1'b0, 1'b0, 4);
    run_event(1'b0, 0, 0, 1'b0, 1'b0, -1);
    for (int e = 0; e < 4; e++)
      run_event(1'($urandom_range(0, 1)), 3, 2, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_event_recorder.md
TUBE_EVENT_RECORDER -- requirements
Module: tube_event_recorder

Interface
REQ-001 Parameter NUM_CH, default 32: number of drift-tube channels, 1..254.
REQ-002 Parameter WIN_CYC, default 255: hit window length in clk100 cycles, 1..(2**TIME_W)-1.
REQ-003 Parameter TIME_W, default 8: width of the hit-time field.
REQ-004 Parameter ID_W, default 8: width of the channel-id field; output word width is TIME_W+ID_W.
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 clk100  in  1  system 100 MHz clock; all logic is on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 trig_in  in  1  scintillator coincidence; a 0->1 transition sampled on clk100 starts an event.
REQ-009 tube_in  in  NUM_CH  drift-tube discriminator levels; bit i is channel i.
REQ-010 zs_en  in  1  zero-suppression enable; sampled only in IDLE.
REQ-011 out_data  out  TIME_W+ID_W  event word: [TIME_W+ID_W-1:ID_W] = time, [ID_W-1:0] = id.
REQ-012 out_valid  out  1  out_data holds a word.
REQ-013 out_ready  in  1  downstream FIFO accepts the word (FIFO not-full).
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 evt_count  out  16  completed events, wraps at 2**16.
REQ-016 missed_trig  out  16  trigger edges ignored while busy, saturates at 16'hFFFF.

Function
REQ-017 States: IDLE, WINDOW, DRAIN, CLEAR.
REQ-018 IDLE->WINDOW on a trig_in rising edge. The window counter is 0 in the first WINDOW cycle. zs_en is latched on this transition.
REQ-019 In WINDOW, for each channel whose hit flag is clear and tube_in[i]=1, hit flag i is set and the current counter value is stored as time i. Only the first hit is kept.
REQ-020 WINDOW->DRAIN in the cycle after the counter equals WIN_CYC-1. Tube levels in that last counter cycle are still captured.
REQ-021 DRAIN word 0 is the header: time field = evt_count[TIME_W-1:0], id = all ones.
REQ-022 After the header, channels are emitted in ascending id, one word per channel.
REQ-022a With latched zs_en=0, every channel is emitted; a channel with no hit carries time = all ones.
REQ-022b With latched zs_en=1, only channels with a hit are emitted.
REQ-023 Handshake: a word transfers on a cycle with out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_data and out_valid hold stable. Back-to-back transfers sustain one word per cycle.
REQ-024 DRAIN->CLEAR in the cycle after the last word transfers. With zs_en=1 and no hits, only the header is sent.
REQ-025 CLEAR lasts one cycle: hit flags and times are cleared, evt_count increments, then the state returns to IDLE.
REQ-026 A trig_in edge in WINDOW, DRAIN or CLEAR does not restart the event; it increments missed_trig instead.
REQ-027 A trig_in level that is still high on return to IDLE does not start an event; a fresh rising edge is required.
REQ-028 out_valid=0 in IDLE, WINDOW and CLEAR.

Reset
REQ-029 rst=1 on a clk100 edge forces, from any state including mid-window and mid-drain:
- state = IDLE
- out_valid = 0, out_data = 0
- all hit flags and times = 0
- evt_count = 0, missed_trig = 0
- trig edge detector = 0
An in-progress event is discarded with no partial words sent.
REQ-030 rst takes priority over every other input in the same cycle.

Structure
REQ-031 A shared package holds the state enumeration, the header id constant (all ones) and the no-hit time sentinel (all ones).
REQ-032 Per-channel capture (hit flag, time register, first-hit logic) is one sub-module, tube_hit_timer, instantiated NUM_CH times.
REQ-033 Channel scan uses an index counter plus a priority search for the next hit; it adds no combinational path from tube_in to out_data.

Verification
REQ-034 Defaults, zs_en=0, out_ready=1, trig at t0, ch3 high from counter 10 and ch7 pulsed at counter 254. Required response:
- words: header 0x00FF, then 0xFF00, 0xFF01, 0xFF02, 0x0A03, ..., 0xFE07, ...
- 33 words total
- evt_count = 1
REQ-035 zs_en=1, ch5 hits at counters 20 and 40. Required: words 0x01FF then 0x1405 only.
REQ-036 zs_en=1, no hits. Required: only the header word, then CLEAR, then IDLE.
REQ-037 out_ready toggled 0/1 every cycle during drain. Required: no word lost or duplicated, out_data stable while stalled, all 33 words in order.
REQ-038 Three trig edges during WINDOW. Required: missed_trig = 3 and exactly one event emitted.
REQ-039 rst asserted on the 5th drain word. Required next cycle: out_valid = 0, busy = 0, evt_count = 0. A following trig produces header 0x00FF.
